// File: rtl/osc_tick_gen.sv
// ---------------------------------------------------------------------------
// osc_tick_gen -- multi-channel tick / clock-enable generator on the HF
// oscillator clock.
//
// After reset release the block waits STARTUP_CYCLES for the oscillator to
// settle, then raises ready. After that, every enabled channel emits a
// one-cycle tick every N cycles and a square wave that toggles on each tick.
// Divide values are runtime-loadable. A new value is staged in a shadow
// register and applied at the end of the running period, so no short or
// long period is ever produced.
//
// Ports
//   clk       in   oscillator clock
//   rst_n     in   asynchronous active-low reset
//   ch_en     in   [NUM_CH]        per-channel run enable (level)
//   div_load  in                   strobe: write div_val into channel div_sel
//   div_sel   in   [SEL_W]         target channel, >= NUM_CH ignored
//   div_val   in   [DIV_W]         new divide value (0 parks the channel)
//   ready     out                  oscillator settled
//   tick      out  [NUM_CH]        one-cycle pulse every N cycles
//   sq        out  [NUM_CH]        square wave, period 2N
//   div_q     out  [NUM_CH*DIV_W]  active divide values, channel 0 in LSBs
// ---------------------------------------------------------------------------

// One tick channel. Holds the period counter, the active divide register,
// the shadow register and the pending-transfer flag.
module osc_tick_ch #(
    parameter int unsigned DIV_W       = 24,
    parameter int unsigned DEFAULT_DIV = 12000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ready_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] val_i,
    output logic             tick_o,
    output logic             sq_o,
    output logic [DIV_W-1:0] div_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             run, wrap, xfer;

    always_comb begin
        // A divide of 0 parks the channel, so run already excludes it and
        // div_q - 1 below cannot underflow while run is high.
        run  = ready_i && en_i && (div_q != '0);
        wrap = run && (cnt_q == div_q - DIV_W'(1));
        // Divide changes are safe whenever no period is in flight, or at
        // the wrap where the next period starts from 0.
        xfer = !run || wrap;

        cnt_d  = (run && !wrap) ? cnt_q + DIV_W'(1) : '0;
        tick_d = wrap;

        sq_d = sq_q;
        if (!(ready_i && en_i)) sq_d = 1'b0;
        else if (wrap)          sq_d = ~sq_q;

        shd_d  = shd_q;
        pend_d = pend_q;
        div_d  = div_q;
        if (load_i) begin
            shd_d  = val_i;
            pend_d = 1'b1;
        end
        // A load in the wrap cycle is applied to the period starting there.
        if (pend_d && xfer) begin
            div_d  = shd_d;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= DIV_W'(DEFAULT_DIV);
            shd_q  <= DIV_W'(DEFAULT_DIV);
            pend_q <= 1'b0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign tick_o = tick_q;
    assign sq_o   = sq_q;
    assign div_o  = div_q;
endmodule

module osc_tick_gen #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DIV_W          = 24,
    parameter int unsigned DEFAULT_DIV    = 12000,
    parameter int unsigned STARTUP_CYCLES = 1200,
    parameter int unsigned SEL_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    div_load,
    input  logic [SEL_W-1:0]        div_sel,
    input  logic [DIV_W-1:0]        div_val,
    output logic                    ready,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       sq,
    output logic [NUM_CH*DIV_W-1:0] div_q
);
    localparam int unsigned CNT_W = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;

    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
    logic             ready_q, ready_d;

    always_comb begin
        st_cnt_d = (st_cnt_q == CNT_W'(STARTUP_CYCLES)) ? st_cnt_q : st_cnt_q + CNT_W'(1);
        // ready lands on the edge where the counter becomes STARTUP_CYCLES;
        // with STARTUP_CYCLES = 0 that is the first edge after release.
        ready_d  = ready_q ||
                   (({1'b0, st_cnt_q} + (CNT_W+1)'(1)) >= (CNT_W+1)'(STARTUP_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_cnt_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            st_cnt_q <= st_cnt_d;
            ready_q  <= ready_d;
        end
    end

    assign ready = ready_q;

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic ld;
            // Out-of-range selects match no channel and are dropped.
            assign ld = div_load && (div_sel == SEL_W'(i));

            osc_tick_ch #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .ready_i (ready_q),
                .en_i    (ch_en[i]),
                .load_i  (ld),
                .val_i   (div_val),
                .tick_o  (tick[i]),
                .sq_o    (sq[i]),
                .div_o   (div_q[i*DIV_W +: DIV_W])
            );
        end
    endgenerate
endmodule

// File: tb/tb_osc_tick_gen.sv
module tb_osc_tick_gen;
    localparam int NC    = 5;
    localparam int DW    = 24;
    localparam int DEF   = 12000;
    localparam int START = 1200;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC-1:0]     ch_en = '0;
    logic              div_load = 1'b0;
    logic [2:0]        div_sel = '0;
    logic [DW-1:0]     div_val = '0;
    logic              ready;
    logic [NC-1:0]     tick;
    logic [NC-1:0]     sq;
    logic [NC*DW-1:0]  div_q;

    osc_tick_gen #(
        .NUM_CH(NC), .DIV_W(DW), .DEFAULT_DIV(DEF), .STARTUP_CYCLES(START)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .div_load(div_load),
        .div_sel(div_sel), .div_val(div_val), .ready(ready), .tick(tick),
        .sq(sq), .div_q(div_q)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: elapsed cycles since release decide ready; each channel
    // counts running cycles in its period and fires when that reaches N.
    int m_elapsed;
    bit m_ready;
    int m_n[NC], m_age[NC], m_pend[NC];
    bit m_tick[NC], m_sq[NC];

    task automatic model_reset();
        m_elapsed = 0;
        m_ready   = 0;
        for (int i = 0; i < NC; i++) begin
            m_n[i] = DEF; m_age[i] = 0; m_pend[i] = -1; m_tick[i] = 0; m_sq[i] = 0;
        end
    endtask

    task automatic model_step();
        bit act, fire;
        for (int i = 0; i < NC; i++) begin
            act  = m_ready && ch_en[i] && (m_n[i] > 0);
            fire = 0;
            if (act) begin
                m_age[i]++;
                if (m_age[i] == m_n[i]) begin fire = 1; m_age[i] = 0; end
            end else m_age[i] = 0;
            m_tick[i] = fire;
            if (!(m_ready && ch_en[i])) m_sq[i] = 0;
            else if (fire)              m_sq[i] = !m_sq[i];
            if (div_load && int'(div_sel) == i) m_pend[i] = int'(div_val);
            if (m_pend[i] >= 0 && (!act || fire)) begin
                m_n[i] = m_pend[i]; m_pend[i] = -1;
            end
        end
        if (m_elapsed < 1000000) m_elapsed++;
        if (m_elapsed >= START) m_ready = 1;
    endtask

    task automatic compare_all();
        logic [NC-1:0] et, es;
        for (int i = 0; i < NC; i++) begin et[i] = m_tick[i]; es[i] = m_sq[i]; end
        chk("ready", ready, m_ready);
        chk("tick", tick, et);
        chk("sq", sq, es);
        for (int i = 0; i < NC; i++) chk($sformatf("div%0d", i), div_q[i*DW +: DW], m_n[i]);
    endtask

    // One clock: model sees the same inputs the DUT samples at this edge.
    task automatic cyc();
        if (rst_n) model_step(); else model_reset();
        @(posedge clk); #1;
        compare_all();
    endtask

    task automatic load(input int sel, input int val);
        div_load = 1'b1; div_sel = sel[2:0]; div_val = val[DW-1:0];
        cyc();
        div_load = 1'b0;
    endtask

    task automatic wait_ready(input int lim, output int n);
        n = 0;
        do begin cyc(); n++; end while (!ready && n < lim);
    endtask

    task automatic wait_tick(input int ch, input int lim, output int n);
        n = 0;
        do begin cyc(); n++; end while (!tick[ch] && n < lim);
    endtask

    int n;
    logic [NC*DW-1:0] snap, def_vec;

    initial begin
        for (int i = 0; i < NC; i++) def_vec[i*DW +: DW] = DW'(DEF);
        model_reset();
        ch_en = '1;
        @(posedge clk); #1;
        cyc(); cyc();                           // reset state checks
        rst_n = 1'b1;

        wait_ready(2000, n);
        chk("ready_latency", n, START);
        wait_tick(0, 13000, n);
        chk("first_tick0", n, DEF);

        // ch1: N=5 loaded while idle, then free-running
        ch_en[1] = 1'b0; load(1, 5); ch_en[1] = 1'b1;
        wait_tick(1, 20, n); chk("ch1_first", n, 5);
        wait_tick(1, 20, n); chk("ch1_period", n, 5);
        repeat (20) cyc();
        chk("ch1_divq", div_q[1*DW +: DW], 5);

        // ch2: N=10, retarget to 4 while the counter is at 3
        ch_en[2] = 1'b0; load(2, 10); ch_en[2] = 1'b1;
        repeat (3) cyc();
        load(2, 4);
        wait_tick(2, 20, n); chk("ch2_old_period", n, 6);
        wait_tick(2, 20, n); chk("ch2_new_period", n, 4);
        wait_tick(2, 20, n); chk("ch2_new_period2", n, 4);

        // ch0: N=3, park with 0 (applies at wrap), then N=1
        ch_en[0] = 1'b0; load(0, 3); ch_en[0] = 1'b1;
        repeat (4) cyc();
        load(0, 0);
        repeat (30) cyc();
        chk("ch0_parked_divq", div_q[0 +: DW], 0);
        load(0, 1);
        repeat (10) cyc();

        // ch3: N=8, drop enable for 7 cycles mid-period
        ch_en[3] = 1'b0; load(3, 8); ch_en[3] = 1'b1;
        repeat (11) cyc();
        ch_en[3] = 1'b0;
        repeat (7) cyc();
        ch_en[3] = 1'b1;
        wait_tick(3, 20, n); chk("ch3_reenable", n, 8);

        // out-of-range selects touch nothing
        snap = div_q;
        load(5, 7); load(6, 9); load(7, 2);
        repeat (3) cyc();
        chk("bad_sel", div_q, snap);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NC; i++)
                if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
            div_load = ($urandom_range(0, 6) == 0);
            div_sel  = 3'($urandom_range(0, 7));
            div_val  = DW'($urandom_range(0, 12));
            cyc();
        end
        div_load = 1'b0;

        // asynchronous reset during active ticking
        ch_en = '1; ch_en[0] = 1'b0; load(0, 1); ch_en[0] = 1'b1;
        repeat (3) cyc();
        chk("pre_reset_tick0", tick[0], 1'b1);
        rst_n = 1'b0;
        #2;
        chk("async_ready", ready, 1'b0);
        chk("async_tick", tick, '0);
        chk("async_sq", sq, '0);
        chk("async_divq", div_q, def_vec);
        model_reset();
        @(posedge clk); #1;
        compare_all();
        rst_n = 1'b1;
        wait_ready(2000, n);
        chk("ready_latency2", n, START);
        repeat (10) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
